apb_initiator: RTL and testbench

APB_INITIATOR -- requirements
Module: apb_initiator

---
 rtl/apb_initiator_pkg.sv | 13 +
 rtl/apb_initiator_if.sv | 35 +++
 rtl/apb_init_wdog.sv | 33 +++
 rtl/apb_initiator.sv | 112 +++++++++++
 tb/tb_apb_initiator.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_initiator_pkg.sv
// Shared types and constants for the APB initiator.
package apb_initiator_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   localparam int TIMEOUT_CYCLES_DEFAULT = 256;

endpackage

// File: rtl/apb_initiator_if.sv
// Core-side request/response and APB bus signals for the APB initiator.
// master: the initiator's view; slave: the view of whatever surrounds it.
interface apb_initiator_if #(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32
);
   logic                      req_i;
   logic [APB_ADDR_WIDTH-1:0] addr_i;
   logic                      we_i;
   logic [APB_DATA_WIDTH-1:0] wdata_i;
   logic                      gnt_o;
   logic                      rvalid_o;
   logic [APB_DATA_WIDTH-1:0] rdata_o;
   logic                      err_o;
   logic [APB_ADDR_WIDTH-1:0] paddr_o;
   logic [APB_DATA_WIDTH-1:0] pwdata_o;
   logic                      pwrite_o;
   logic                      psel_o;
   logic                      penable_o;
   logic [APB_DATA_WIDTH-1:0] prdata_i;
   logic                      pready_i;
   logic                      pslverr_i;

   modport master (
      input  req_i, addr_i, we_i, wdata_i, prdata_i, pready_i, pslverr_i,
      output gnt_o, rvalid_o, rdata_o, err_o, paddr_o, pwdata_o, pwrite_o,
             psel_o, penable_o
   );

   modport slave (
      output req_i, addr_i, we_i, wdata_i, prdata_i, pready_i, pslverr_i,
      input  gnt_o, rvalid_o, rdata_o, err_o, paddr_o, pwdata_o, pwrite_o,
             psel_o, penable_o
   );
endinterface

// File: rtl/apb_init_wdog.sv
// ACCESS-phase watchdog: down-counter loaded during SETUP, decremented on
// every ACCESS cycle; expires on the TIMEOUT_CYCLES-th ACCESS cycle.
module apb_init_wdog
   import apb_initiator_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic load_i,
   input  logic tick_i,
   output logic expired_o
);
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;

   // reload at the start of each transfer, count down through ACCESS
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= CNT_LOAD;
      end else if (tick_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_LAST;
      end
   end

   assign expired_o = tick_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/apb_initiator.sv
// APB initiator: turns single core-side requests into APB SETUP/ACCESS
// transfers and returns one response strobe per transfer.
// Optional ACCESS-phase timeout: define APB_INITIATOR_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | bus idle, gnt_o follows req_i, request captured on grant
// SETUP  | psel=1 penable=0, one cycle
// ACCESS | psel=1 penable=1, waiting for pready (or timeout)
// RESP   | rvalid_o pulse with rdata_o/err_o, bus released
module apb_initiator
   import apb_initiator_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   apb_initiator_if.master bus
);
   apb_state_e                state_q;
   logic [APB_ADDR_WIDTH-1:0] paddr_q;
   logic [APB_DATA_WIDTH-1:0] pwdata_q;
   logic [APB_DATA_WIDTH-1:0] rdata_q;
   logic                      pwrite_q;
   logic                      psel_q;
   logic                      penable_q;
   logic                      rvalid_q;
   logic                      err_q;
   logic                      timeout_hit;

   if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
      $error("TIMEOUT_CYCLES must be at least 1");
   end

`ifdef APB_INITIATOR_TIMEOUT_EN
   apb_init_wdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .load_i   (state_q == SETUP),
      .tick_i   (state_q == ACCESS),
      .expired_o(timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   assign bus.gnt_o = (state_q == IDLE) && bus.req_i;

   // transfer sequencer; pready takes priority over a coincident timeout
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         rdata_q   <= '0;
         pwrite_q  <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               rvalid_q <= 1'b0;
               if (bus.req_i) begin
                  paddr_q  <= bus.addr_i;
                  pwrite_q <= bus.we_i;
                  pwdata_q <= bus.wdata_i;
                  psel_q   <= 1'b1;
                  state_q  <= SETUP;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
            end
            ACCESS: begin
               if (bus.pready_i || timeout_hit) begin
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  state_q   <= RESP;
                  if (bus.pready_i) begin
                     rdata_q <= pwrite_q ? '0 : bus.prdata_i;
                     err_q   <= bus.pslverr_i;
                  end else begin
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                  end
               end
            end
            default: begin
               rvalid_q <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign bus.paddr_o   = paddr_q;
   assign bus.pwdata_o  = pwdata_q;
   assign bus.pwrite_o  = pwrite_q;
   assign bus.psel_o    = psel_q;
   assign bus.penable_o = penable_q;
   assign bus.rvalid_o  = rvalid_q;
   assign bus.rdata_o   = rdata_q;
   assign bus.err_o     = err_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Scoreboard bench for apb_initiator: stimulus pushes expected responses,
// a monitor pops and compares on every rvalid_o.
module tb_apb_initiator;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;
   localparam int NEVER = 1000000;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      int            due;
      int            n_access;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   exp_t          sb[$];
   int            gnt_cyc = -100;
   int            last_gnt = -100;
   logic [AW-1:0] exp_addr = '0;
   logic          exp_w = 1'b0;
   logic [DW-1:0] exp_wd = '0;
   int            cfg_waits = 0;
   logic [DW-1:0] cfg_prdata = '0;
   logic          cfg_slverr = 1'b0;
   int            acc_cnt = 0;

   apb_initiator_if #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

   apb_initiator #(
      .APB_ADDR_WIDTH(AW),
      .APB_DATA_WIDTH(DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // drive one request; expectation is pushed when the grant is seen
   task automatic issue(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                        input int waits, input logic [DW-1:0] prd, input logic serr,
                        input logic [DW-1:0] exp_rd, input logic exp_err, input int exp_acc,
                        input int exp_gap, input bit hold);
      exp_t e;
      bit   got;
      got = 0;
      @(negedge clk);
      bus.req_i   = 1'b1;
      bus.addr_i  = a;
      bus.we_i    = w;
      bus.wdata_i = wd;
      for (int i = 0; i < 50 && !got; i++) begin
         #1;
         if (bus.gnt_o) got = 1;
         else @(negedge clk);
      end
      check("grant_seen", 64'(got), 64'd1);
      if (got) begin
         gnt_cyc = cyc;
         if (exp_gap > 0) check("grant_spacing", 64'(gnt_cyc - last_gnt), 64'(exp_gap));
         last_gnt   = gnt_cyc;
         exp_addr   = a;
         exp_w      = w;
         exp_wd     = wd;
         cfg_waits  = waits;
         cfg_prdata = prd;
         cfg_slverr = serr;
         e.rdata    = exp_rd;
         e.err      = exp_err;
         e.due      = gnt_cyc + 2 + exp_acc;
         e.n_access = exp_acc;
         sb.push_back(e);
      end
      if (!hold || !got) begin
         @(negedge clk);
         bus.req_i = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         #3;
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL response_timeout pending=%0d required=0", sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   // APB completer: pready after cfg_waits wait states
   initial begin
      bus.pready_i  = 1'b0;
      bus.prdata_i  = '0;
      bus.pslverr_i = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.psel_o && bus.penable_o) begin
            bus.pready_i  = (acc_cnt == cfg_waits);
            bus.prdata_i  = cfg_prdata;
            bus.pslverr_i = cfg_slverr;
            acc_cnt++;
         end else begin
            bus.pready_i  = 1'b0;
            bus.prdata_i  = 32'h0BAD_0BAD;
            bus.pslverr_i = 1'b1;
            acc_cnt = 0;
         end
      end
   end

   // monitor / scoreboard
   initial begin
      exp_t          e;
      int            acc_seen;
      logic          prev_rvalid;
      logic [DW-1:0] prev_rdata;
      logic          prev_err;
      acc_seen = 0;
      prev_rvalid = 1'b0;
      prev_rdata = '0;
      prev_err = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            acc_seen = 0;
            prev_rvalid = 1'b0;
            continue;
         end
         if (bus.psel_o && bus.penable_o) begin
            acc_seen++;
            check("paddr_stable", 64'(bus.paddr_o), 64'(exp_addr));
            check("pwrite_stable", 64'(bus.pwrite_o), 64'(exp_w));
            check("pwdata_stable", 64'(bus.pwdata_o), 64'(exp_wd));
         end
         if (bus.psel_o && !bus.penable_o)
            check("setup_cycle", 64'(cyc), 64'(gnt_cyc + 1));
         if (bus.req_i && (bus.psel_o || bus.rvalid_o))
            check("gnt_when_busy", 64'(bus.gnt_o), 64'd0);
         if (prev_rvalid) begin
            check("rvalid_one_cycle", 64'(bus.rvalid_o), 64'd0);
            check("rdata_hold", 64'(bus.rdata_o), 64'(prev_rdata));
            check("err_hold", 64'(bus.err_o), 64'(prev_err));
         end
         if (bus.rvalid_o) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rvalid actual=1 required=0 (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               check("rdata", 64'(bus.rdata_o), 64'(e.rdata));
               check("err", 64'(bus.err_o), 64'(e.err));
               check("rvalid_cycle", 64'(cyc), 64'(e.due));
               check("access_cycles", 64'(acc_seen), 64'(e.n_access));
               check("psel_in_resp", 64'(bus.psel_o), 64'd0);
            end
            acc_seen = 0;
         end
         prev_rvalid = bus.rvalid_o;
         prev_rdata  = bus.rdata_o;
         prev_err    = bus.err_o;
      end
   end

   initial begin
      int bad;
      bus.req_i   = 1'b0;
      bus.addr_i  = '0;
      bus.we_i    = 1'b0;
      bus.wdata_i = '0;
      #1 rst_n = 1'b0;
      #2;
      check("rst_psel", 64'(bus.psel_o), 64'd0);
      check("rst_penable", 64'(bus.penable_o), 64'd0);
      check("rst_pwrite", 64'(bus.pwrite_o), 64'd0);
      check("rst_paddr", 64'(bus.paddr_o), 64'd0);
      check("rst_pwdata", 64'(bus.pwdata_o), 64'd0);
      check("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
      check("rst_rdata", 64'(bus.rdata_o), 64'd0);
      check("rst_err", 64'(bus.err_o), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // zero-wait read
      issue(32'h1A10_0000, 1'b0, '0, 0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1, 0, 0);
      wait_idle();
      // write with 3 wait states captures 0
      issue(32'h1A10_1008, 1'b1, 32'h0000_00FF, 3, 32'h1234_5678, 1'b0, '0, 1'b0, 4, 0, 0);
      wait_idle();
      // slave error then clean read
      issue(32'h1A10_0010, 1'b0, '0, 0, 32'hCAFE_0001, 1'b1, 32'hCAFE_0001, 1'b1, 1, 0, 0);
      wait_idle();
      issue(32'h1A10_0014, 1'b0, '0, 1, 32'hCAFE_0002, 1'b0, 32'hCAFE_0002, 1'b0, 2, 0, 0);
      wait_idle();
      // req held high across three reads
      issue(32'h0000_0100, 1'b0, '0, 0, 32'hA5A5_0001, 1'b0, 32'hA5A5_0001, 1'b0, 1, 0, 1);
      issue(32'h0000_0104, 1'b0, '0, 0, 32'hA5A5_0002, 1'b0, 32'hA5A5_0002, 1'b0, 1, 4, 1);
      issue(32'h0000_0108, 1'b0, '0, 0, 32'hA5A5_0003, 1'b0, 32'hA5A5_0003, 1'b0, 1, 4, 0);
      wait_idle();

`ifdef APB_INITIATOR_TIMEOUT_EN
      // no pready: abort after TO access cycles
      issue(32'h2000_0000, 1'b0, '0, NEVER, 32'h5555_AAAA, 1'b0, '0, 1'b1, TO, 0, 0);
      wait_idle();
      // pready on the last allowed cycle is a normal completion
      issue(32'h2000_0004, 1'b0, '0, TO - 1, 32'h7777_0000, 1'b0, 32'h7777_0000, 1'b0, TO, 0, 0);
      wait_idle();
`endif

      // stalled transfer, then reset in ACCESS
      issue(32'h3000_0000, 1'b0, '0, NEVER, 32'h1111_2222, 1'b0, '0, 1'b1, 1, 0, 0);
`ifndef APB_INITIATOR_TIMEOUT_EN
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         #2;
         if (!bus.psel_o || bus.rvalid_o) bad++;
      end
      check("no_timeout_stall", 64'(bad), 64'd0);
`endif
      @(negedge clk);
      #3;
      check("in_access_before_reset", 64'({bus.psel_o, bus.penable_o}), 64'h3);
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("reset_psel", 64'(bus.psel_o), 64'd0);
      check("reset_penable", 64'(bus.penable_o), 64'd0);
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         #2;
         if (bus.rvalid_o) bad++;
      end
      check("reset_no_rvalid", 64'(bad), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(32'h1A10_0020, 1'b0, '0, 0, 32'h0BEE_F00D, 1'b0, 32'h0BEE_F00D, 1'b0, 1, 0, 0);
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench did not finish");
   end

endmodule
